// File: rtl/sd_cmd_responder_if.sv
// SD CMD-line bundle between the host side and the card-side responder,
// plus the decoded-command and status outputs the card exposes.
interface sd_cmd_responder_if;
  logic        sd_clk;
  logic        cmd;
  logic        cmd_out;
  logic        cmd_oe;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        crc_err;
  logic [3:0]  card_state;
  logic        busy;

  modport master (
    output sd_clk, cmd,
    input  cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, card_state, busy
  );

  modport slave (
    input  sd_clk, cmd,
    output cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, card_state, busy
  );
endinterface

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD responder: receives 48-bit host commands, checks CRC7,
// tracks a reduced card state machine and answers with R1/R2/R3/R6.
module sd_cmd_responder #(
  parameter logic [15:0]  RCA = 16'h0020,
  parameter logic [127:0] CID = 128'h0353_4453_4430_3030_8000_0000_0001_0001,
  parameter logic [31:0]  OCR = 32'h80FF_8000
) (
  input  logic              clk,
  input  logic              rst,
  sd_cmd_responder_if.slave bus
);
  localparam int unsigned FRAME_W = 48;
  localparam int unsigned TX_W    = 136;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 6;

  localparam logic [CNT_W-1:0] LEN_SHORT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LEN_LONG  = CNT_W'(TX_W);
  localparam logic [BIT_W-1:0] BIT_TRANS = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RX    = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;

  localparam logic [3:0] CS_IDLE  = 4'd0;
  localparam logic [3:0] CS_READY = 4'd1;
  localparam logic [3:0] CS_IDENT = 4'd2;
  localparam logic [3:0] CS_STBY  = 4'd3;
  localparam logic [3:0] CS_TRAN  = 4'd4;

  localparam logic [2:0] RSP_NONE = 3'd0;
  localparam logic [2:0] RSP_R1   = 3'd1;
  localparam logic [2:0] RSP_R2   = 3'd2;
  localparam logic [2:0] RSP_R3   = 3'd3;
  localparam logic [2:0] RSP_R6   = 3'd4;

  // CRC7, polynomial x^7+x^3+1, zero seed, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0]  c;
    logic [39:0] d;
    logic        fb;
    c = '0;
    d = data;
    for (int i = 0; i < 40; i++) begin
      fb = d[39] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      d  = {d[38:0], 1'b0};
    end
    return c;
  endfunction

  logic [1:0] sclk_sync;
  logic [1:0] cmd_sync;
  logic       sclk_prev;
  logic       rise;
  logic       fall;
  logic       cmd_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cmd_sync  <= 2'b11;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.sd_clk};
      cmd_sync  <= {cmd_sync[0], bus.cmd};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign rise    = sclk_sync[1] & ~sclk_prev;
  assign fall    = ~sclk_sync[1] & sclk_prev;
  assign cmd_bit = cmd_sync[1];

  logic [2:0]         state_q, state_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TX_W-1:0]    tx_q, tx_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic               wait_q, wait_d;
  logic               cmd_out_q, cmd_out_d;
  logic               cmd_oe_q, cmd_oe_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               crc_err_q, crc_err_d;
  logic [5:0]         cmd_index_q, cmd_index_d;
  logic [31:0]        cmd_arg_q, cmd_arg_d;
  logic [3:0]         card_state_q, card_state_d;
  logic               busy_q, busy_d;
  logic               app_q, app_d;

  logic [5:0]       rx_idx;
  logic [31:0]      rx_arg;
  logic             crc_ok;
  logic [31:0]      status;
  logic [2:0]       rsp;
  logic [3:0]       dec_state;
  logic [31:0]      rsp_arg;
  logic [39:0]      r1_body;
  logic [TX_W-1:0]  rsp_frame;
  logic [CNT_W-1:0] rsp_len;

  assign rx_idx = rx_q[45:40];
  assign rx_arg = rx_q[39:8];
  assign crc_ok = (crc7(rx_q[47:8]) == rx_q[7:1]) && rx_q[0];
  // CMD55's own R1 already reports APP_CMD set
  assign status = {19'b0, card_state_q, 3'b0, (rx_idx == 6'd55) | app_q, 5'b0};

  // Card-state rules and response selection for the frame in rx_q
  always_comb begin
    rsp       = RSP_NONE;
    dec_state = card_state_q;
    case (rx_idx)
      6'd0:  dec_state = CS_IDLE;
      6'd55: rsp = RSP_R1;
      6'd41: if (app_q && card_state_q == CS_IDLE) begin
               dec_state = CS_READY;
               rsp       = RSP_R3;
             end
      6'd2:  if (card_state_q == CS_READY) begin
               dec_state = CS_IDENT;
               rsp       = RSP_R2;
             end
      6'd3:  if (card_state_q == CS_IDENT || card_state_q == CS_STBY) begin
               dec_state = CS_STBY;
               rsp       = RSP_R6;
             end
      6'd7:  if (rx_arg[31:16] == RCA) begin
               if (card_state_q == CS_STBY || card_state_q == CS_TRAN) begin
                 dec_state = CS_TRAN;
                 rsp       = RSP_R1;
               end
             end else begin
               dec_state = CS_STBY;
             end
      6'd17: if (card_state_q == CS_TRAN) rsp = RSP_R1;
      default: ;
    endcase

    rsp_arg = (rsp == RSP_R6) ? {RCA, status[15:0]} : status;
    r1_body = {2'b00, rx_idx, rsp_arg};
    case (rsp)
      RSP_R1, RSP_R6: begin
        rsp_frame = {r1_body, crc7(r1_body), 1'b1, 88'b0};
        rsp_len   = LEN_SHORT;
      end
      RSP_R3: begin
        rsp_frame = {2'b00, 6'h3F, OCR, 7'h7F, 1'b1, 88'b0};
        rsp_len   = LEN_SHORT;
      end
      RSP_R2: begin
        rsp_frame = {2'b00, 6'h3F, CID[127:1], 1'b1};
        rsp_len   = LEN_LONG;
      end
      default: begin
        rsp_frame = '0;
        rsp_len   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      tx_cnt_q     <= '0;
      wait_q       <= 1'b0;
      cmd_out_q    <= 1'b1;
      cmd_oe_q     <= 1'b0;
      cmd_valid_q  <= 1'b0;
      crc_err_q    <= 1'b0;
      cmd_index_q  <= '0;
      cmd_arg_q    <= '0;
      card_state_q <= CS_IDLE;
      busy_q       <= 1'b0;
      app_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      tx_cnt_q     <= tx_cnt_d;
      wait_q       <= wait_d;
      cmd_out_q    <= cmd_out_d;
      cmd_oe_q     <= cmd_oe_d;
      cmd_valid_q  <= cmd_valid_d;
      crc_err_q    <= crc_err_d;
      cmd_index_q  <= cmd_index_d;
      cmd_arg_q    <= cmd_arg_d;
      card_state_q <= card_state_d;
      busy_q       <= busy_d;
      app_q        <= app_d;
    end
  end

  // Protocol FSM: receive on rises, transmit on falls
  always_comb begin
    state_d      = state_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    tx_cnt_d     = tx_cnt_q;
    wait_d       = wait_q;
    cmd_out_d    = cmd_out_q;
    cmd_oe_d     = cmd_oe_q;
    cmd_valid_d  = 1'b0;
    crc_err_d    = 1'b0;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;
    card_state_d = card_state_q;
    busy_d       = busy_q;
    app_d        = app_q;

    case (state_q)
      S_IDLE: begin
        if (rise && !cmd_bit) begin
          state_d   = S_RX;
          rx_d      = '0;
          bit_cnt_d = BIT_W'(1);
          busy_d    = 1'b1;
        end
      end
      S_RX: begin
        if (rise) begin
          rx_d      = {rx_q[FRAME_W-2:0], cmd_bit};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_TRANS && !cmd_bit) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (!crc_ok) begin
          crc_err_d = 1'b1;
          state_d   = S_IDLE;
          busy_d    = 1'b0;
        end else begin
          cmd_valid_d  = 1'b1;
          cmd_index_d  = rx_idx;
          cmd_arg_d    = rx_arg;
          card_state_d = dec_state;
          app_d        = (rx_idx == 6'd55);
          tx_d         = rsp_frame;
          tx_cnt_d     = rsp_len;
          wait_d       = 1'b0;
          state_d      = (rsp == RSP_NONE) ? S_IDLE : S_WAIT;
          busy_d       = (rsp != RSP_NONE);
        end
      end
      S_WAIT: begin
        // NCR: start bit goes out on the second fall
        if (fall) begin
          if (!wait_q) begin
            wait_d = 1'b1;
          end else begin
            cmd_oe_d  = 1'b1;
            cmd_out_d = tx_q[TX_W-1];
            tx_d      = {tx_q[TX_W-2:0], 1'b0};
            tx_cnt_d  = tx_cnt_q - CNT_W'(1);
            state_d   = S_TX;
          end
        end
      end
      S_TX: begin
        if (fall) begin
          if (tx_cnt_q == '0) begin
            cmd_oe_d  = 1'b0;
            cmd_out_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            cmd_out_d = tx_q[TX_W-1];
            tx_d      = {tx_q[TX_W-2:0], 1'b0};
            tx_cnt_d  = tx_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_out    = cmd_out_q;
  assign bus.cmd_oe     = cmd_oe_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.crc_err    = crc_err_q;
  assign bus.cmd_index  = cmd_index_q;
  assign bus.cmd_arg    = cmd_arg_q;
  assign bus.card_state = card_state_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: acts as the SD host, drives directed and random
// commands and checks responses against a card model kept here.
module tb_sd_cmd_responder;
  localparam int HALF = 4;
  localparam logic [15:0]  RCA = 16'h0020;
  localparam logic [127:0] CID = 128'h0353_4453_4430_3030_8000_0000_0001_0001;
  localparam logic [31:0]  OCR = 32'h80FF_8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_cmd_responder_if bus();
  sd_cmd_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  int          m_state;
  bit          m_app;
  logic [5:0]  last_idx;
  logic [31:0] last_arg;

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) valid_cnt++;
    if (bus.crc_err === 1'b1) err_cnt++;
  end

  // CRC7 as polynomial long division by 0x89
  function automatic logic [6:0] ref_crc7(input logic [39:0] data);
    logic [46:0] m;
    m = {data, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic [135:0] short_rsp(input logic [5:0] idx, input logic [31:0] a);
    logic [39:0] body;
    body = {2'b00, idx, a};
    return {body, ref_crc7(body), 1'b1, 88'b0};
  endfunction

  // Card model: applies a good command, returns expected response bits
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           output int len, output logic [135:0] rsp);
    logic [31:0] status;
    status = (32'(m_state) << 9) | ((idx == 6'd55 || m_app) ? 32'h20 : 32'h0);
    len = 0;
    rsp = '0;
    case (idx)
      6'd0:  m_state = 0;
      6'd55: begin len = 48; rsp = short_rsp(idx, status); end
      6'd41: if (m_app && m_state == 0) begin
               m_state = 1; len = 48;
               rsp = {2'b00, 6'h3F, OCR, 7'h7F, 1'b1, 88'b0};
             end
      6'd2:  if (m_state == 1) begin
               m_state = 2; len = 136;
               rsp = {2'b00, 6'h3F, CID[127:1], 1'b1};
             end
      6'd3:  if (m_state == 2 || m_state == 3) begin
               len = 48; rsp = short_rsp(idx, {RCA, status[15:0]}); m_state = 3;
             end
      6'd7:  if (arg[31:16] == RCA) begin
               if (m_state == 3 || m_state == 4) begin
                 len = 48; rsp = short_rsp(idx, status); m_state = 4;
               end
             end else m_state = 3;
      6'd17: if (m_state == 4) begin len = 48; rsp = short_rsp(idx, status); end
      default: ;
    endcase
    m_app = (idx == 6'd55);
  endtask

  task automatic send_frame(input logic [47:0] frame);
    for (int b = 47; b >= 0; b--) begin
      bus.sd_clk = 1'b0; bus.cmd = frame[b];
      repeat (HALF) @(negedge clk);
      bus.sd_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    bus.cmd = 1'b1;
  endtask

  task automatic run_cmd(input string name, input logic [5:0] idx,
                         input logic [31:0] arg, input int flip);
    logic [39:0]  body;
    logic [47:0]  frame;
    logic [135:0] exp_rsp, got;
    int exp_len, v0, e0, first, nbits, budget, want_first;
    bit bad;
    body  = {2'b01, idx, arg};
    frame = {body, ref_crc7(body), 1'b1};
    bad   = (flip >= 0);
    if (bad) frame[flip] = ~frame[flip];
    exp_len = 0; exp_rsp = '0;
    if (!bad) begin
      model_cmd(idx, arg, exp_len, exp_rsp);
      last_idx = idx; last_arg = arg;
    end
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(frame);
    got = '0; first = 0; nbits = 0;
    budget = (exp_len > 0) ? exp_len + 4 : 8;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      bus.sd_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (bus.cmd_oe === 1'b1) begin
        if (first == 0) first = cyc;
        if (nbits < 136) got[135 - nbits] = bus.cmd_out;
        nbits++;
      end
      bus.sd_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    want_first = (exp_len > 0) ? 2 : 0;
    tests++; if ((valid_cnt - v0) !== (bad ? 0 : 1)) begin fails++;
      $display("FAIL %s valid_pulses: got %0d want %0d", name, valid_cnt - v0, bad ? 0 : 1); end
    tests++; if ((err_cnt - e0) !== (bad ? 1 : 0)) begin fails++;
      $display("FAIL %s crc_err_pulses: got %0d want %0d", name, err_cnt - e0, bad ? 1 : 0); end
    tests++; if (first !== want_first) begin fails++;
      $display("FAIL %s start_fall: got %0d want %0d", name, first, want_first); end
    tests++; if (nbits !== exp_len) begin fails++;
      $display("FAIL %s rsp_len: got %0d want %0d", name, nbits, exp_len); end
    tests++; if (got !== exp_rsp) begin fails++;
      $display("FAIL %s rsp_bits: got %h want %h", name, got, exp_rsp); end
    tests++; if (bus.cmd_index !== last_idx || bus.cmd_arg !== last_arg) begin fails++;
      $display("FAIL %s cmd_fields: got %0d/%h want %0d/%h", name, bus.cmd_index, bus.cmd_arg, last_idx, last_arg); end
    tests++; if (bus.card_state !== 4'(m_state)) begin fails++;
      $display("FAIL %s card_state: got %0d want %0d", name, bus.card_state, m_state); end
    tests++; if (bus.busy !== 1'b0 || bus.cmd_oe !== 1'b0 || bus.cmd_out !== 1'b1) begin fails++;
      $display("FAIL %s line_idle: got busy=%b oe=%b out=%b want 0 0 1", name, bus.busy, bus.cmd_oe, bus.cmd_out); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sd_clk = 1'b1; bus.cmd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_state = 0; m_app = 0; last_idx = '0; last_arg = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.cmd_out !== 1'b1 || bus.cmd_oe !== 1'b0) begin fails++;
      $display("FAIL reset_line: got out=%b oe=%b want 1 0", bus.cmd_out, bus.cmd_oe); end
    tests++; if (bus.cmd_valid !== 1'b0 || bus.crc_err !== 1'b0 || bus.busy !== 1'b0) begin fails++;
      $display("FAIL reset_flags: got valid=%b err=%b busy=%b want 0 0 0", bus.cmd_valid, bus.crc_err, bus.busy); end
    tests++; if (bus.cmd_index !== 6'd0 || bus.cmd_arg !== 32'd0 || bus.card_state !== 4'd0) begin fails++;
      $display("FAIL reset_regs: got idx=%0d arg=%h st=%0d want 0 0 0", bus.cmd_index, bus.cmd_arg, bus.card_state); end
  endtask

  task automatic test_cmd0();
    run_cmd("cmd0", 6'd0, 32'h0, -1);
  endtask

  task automatic test_acmd41();
    run_cmd("cmd55", 6'd55, 32'h0, -1);
    run_cmd("acmd41", 6'd41, 32'h40FF_8000, -1);
  endtask

  task automatic test_ident();
    run_cmd("cmd2", 6'd2, 32'h0, -1);
    run_cmd("cmd3", 6'd3, 32'h0, -1);
  endtask

  task automatic test_select();
    run_cmd("cmd7", 6'd7, 32'h0020_0000, -1);
    run_cmd("cmd17", 6'd17, 32'h0, -1);
  endtask

  task automatic test_crc_error();
    run_cmd("cmd17_badcrc", 6'd17, 32'h0, 3);
    run_cmd("cmd17_after", 6'd17, 32'h0000_1234, -1);
  endtask

  // Transmission bit 0 must abort silently
  task automatic test_abort();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.sd_clk = 1'b0; bus.cmd = (cyc < 2) ? 1'b0 : 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sd_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    tests++; if ((valid_cnt - v0) !== 0 || (err_cnt - e0) !== 0) begin fails++;
      $display("FAIL abort_pulses: got valid=%0d err=%0d want 0 0", valid_cnt - v0, err_cnt - e0); end
    tests++; if (bus.busy !== 1'b0 || bus.cmd_oe !== 1'b0) begin fails++;
      $display("FAIL abort_idle: got busy=%b oe=%b want 0 0", bus.busy, bus.cmd_oe); end
    run_cmd("cmd17_after_abort", 6'd17, 32'h0, -1);
  endtask

  task automatic test_random();
    logic [5:0]  idx;
    logic [31:0] arg;
    int flip;
    for (int n = 0; n < 20; n++) begin
      arg = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        case (m_state)
          0: idx = m_app ? 6'd41 : 6'd55;
          1: idx = 6'd2;
          2: idx = 6'd3;
          3: begin idx = 6'd7; arg[31:16] = RCA; end
          default: idx = ($urandom_range(0, 2) == 0) ? 6'd7 : 6'd17;
        endcase
      end else begin
        idx = 6'($urandom_range(0, 63));
      end
      flip = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 45)) : -1;
      run_cmd("random", idx, arg, flip);
    end
  endtask

  // Reset in the middle of an R2 must release the line at once
  task automatic test_reset_mid_tx();
    logic [39:0] body;
    bit hit;
    run_cmd("rst_cmd0", 6'd0, 32'h0, -1);
    run_cmd("rst_cmd55", 6'd55, 32'h0, -1);
    run_cmd("rst_acmd41", 6'd41, 32'h40FF_8000, -1);
    body = {2'b01, 6'd2, 32'h0};
    send_frame({body, ref_crc7(body), 1'b1});
    hit = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      bus.sd_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (cyc == 21) begin
        hit = 1;
        tests++; if (bus.cmd_oe !== 1'b1) begin fails++;
          $display("FAIL rst_in_tx: got oe=%b want 1", bus.cmd_oe); end
        rst = 1'b1;
        #1;
        tests++; if (bus.cmd_oe !== 1'b0 || bus.cmd_out !== 1'b1) begin fails++;
          $display("FAIL rst_release: got oe=%b out=%b want 0 1", bus.cmd_oe, bus.cmd_out); end
        tests++; if (bus.card_state !== 4'd0 || bus.busy !== 1'b0) begin fails++;
          $display("FAIL rst_state: got st=%0d busy=%b want 0 0", bus.card_state, bus.busy); end
        break;
      end
      bus.sd_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    tests++; if (!hit) begin fails++;
      $display("FAIL rst_reached: got 0 want 1"); end
    bus.sd_clk = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_state = 0; m_app = 0; last_idx = '0; last_arg = '0;
    run_cmd("cmd0_after_rst", 6'd0, 32'h0, -1);
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_acmd41();
    test_ident();
    test_select();
    test_crc_error();
    test_abort();
    test_random();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
